// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and bit helpers used by the schedule,
// round-core and padder blocks.
package sha256_pkg;
  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int ROUNDS    = 64;

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t maj3(input word_t a, input word_t b, input word_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / schedule-word-out handshake bundle for the message schedule.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic         flush;
  logic [511:0] blk;
  logic         blk_valid;
  logic         blk_ready;
  word_t        w_word;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         w_valid;
  logic         w_ready;

  modport master (output flush, blk, blk_valid, w_ready,
                  input  blk_ready, w_word, w_idx, w_last, w_valid);
  modport slave  (input  flush, blk, blk_valid, w_ready,
                  output blk_ready, w_word, w_idx, w_last, w_valid);
endinterface

// File: rtl/sha256_msg_schedule_sigma.sv
// SHA-256 small-sigma functions used by the schedule expansion.
module s0s
  import sha256_pkg::*;
(
  input  word_t i_x,
  output word_t o_y
);
  assign o_y = rotr(i_x, 7) ^ rotr(i_x, 18) ^ (i_x >> 3);
endmodule

module s1s
  import sha256_pkg::*;
(
  input  word_t i_x,
  output word_t o_y
);
  assign o_y = rotr(i_x, 17) ^ rotr(i_x, 19) ^ (i_x >> 10);
endmodule

// File: rtl/sha256_msg_schedule.sv
// Streams W[0..63] for one 512-bit block from a 16-word sliding window,
// producing W[t+16] as W[t] leaves the window.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  sha256_msg_schedule_if.slave        bus
);
  state_t     r_state, w_state_nxt;
  logic [5:0] r_t;
  word_t      r_win [BLK_WORDS];
  logic       w_fire, w_accept;
  word_t      w_sig0, w_sig1;
  word_t      w_s1, w_c1, w_s2, w_c2, w_new;

  s0s u_s0 (.i_x(r_win[1]),  .o_y(w_sig0));
  s1s u_s1 (.i_x(r_win[14]), .o_y(w_sig1));

  // Two carry-save stages collapse the 4 operands to 2 before the single CPA;
  // the <<1 drops carries out of bit 31, giving the mod 2^32 sum.
  assign w_s1  = w_sig1 ^ r_win[9] ^ w_sig0;
  assign w_c1  = maj3(w_sig1, r_win[9], w_sig0) << 1;
  assign w_s2  = w_s1 ^ w_c1 ^ r_win[0];
  assign w_c2  = maj3(w_s1, w_c1, r_win[0]) << 1;
  assign w_new = w_s2 + w_c2;

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (bus.blk_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: if (bus.w_ready) begin
        w_fire = 1'b1;
        if (r_t == 6'(ROUNDS - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_fire      = 1'b0;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t <= '0;
      for (int i = 0; i < BLK_WORDS; i++) r_win[i] <= '0;
    end else if (bus.flush) begin
      r_t <= '0;
    end else if (w_accept) begin
      r_t <= '0;
      for (int i = 0; i < BLK_WORDS; i++)
        r_win[i] <= bus.blk[(BLK_WORDS-1-i)*WORD_W +: WORD_W];
    end else if (w_fire) begin
      r_t <= r_t + 6'd1;
      for (int i = 0; i < BLK_WORDS-1; i++) r_win[i] <= r_win[i+1];
      r_win[BLK_WORDS-1] <= w_new;
    end
  end

  assign bus.blk_ready = (r_state == IDLE);
  assign bus.w_valid   = (r_state == RUN);
  assign bus.w_word    = r_win[0];
  assign bus.w_idx     = r_t;
  assign bus.w_last    = (r_state == RUN) && (r_t == 6'(ROUNDS - 1));
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench: known-answer table plus scoreboard of model words,
// with stall, flush, async reset and back-to-back sequences.
module tb_sha256_msg_schedule;
  logic clk, rst;
  sha256_msg_schedule_if bus ();

  sha256_msg_schedule dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] word;
    logic        last;
  } exp_t;

  typedef struct {
    logic [511:0] blk;
    int           idx;
    logic [31:0]  w;
  } vec_t;

  int          n_chk, n_pass, nf, cyc;
  exp_t        sb[$];
  int          acc_q[$], last_q[$];
  logic [31:0] cap_w [64];
  logic [511:0] abc_blk, zero_blk, ff_blk;
  vec_t        tbl [12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ref_w(input logic [511:0] b, input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
    return w[t];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || bus.flush) begin
        sb.delete();
      end else begin
        if (bus.w_valid && bus.w_ready) begin
          nf++;
          if (sb.size() == 0) chk("sb_unexpected_word", {58'd0, bus.w_idx}, 64'hdead);
          else begin
            e = sb.pop_front();
            chk("sb_word", bus.w_word, e.word);
            chk("sb_idx",  bus.w_idx,  e.idx);
            chk("sb_last", bus.w_last, e.last);
          end
          cap_w[bus.w_idx] = bus.w_word;
          if (bus.w_last) last_q.push_back(cyc + 1);
        end
        if (bus.blk_valid && bus.blk_ready) begin
          for (int t = 0; t < 64; t++) sb.push_back({6'(t), ref_w(bus.blk, t), t == 63});
          acc_q.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int t, input int budget);
    int n = 0;
    while (!(bus.w_valid && bus.w_idx == 6'(t)) && n < budget) begin tick(); n++; end
    chk($sformatf("wait_idx_%0d", t), n < budget, 1);
  endtask

  task automatic start_block(input logic [511:0] b);
    int n = 0;
    bus.blk = b;
    bus.blk_valid = 1'b1;
    while (!bus.blk_ready && n < 100) begin tick(); n++; end
    tick();
    bus.blk_valid = 1'b0;
  endtask

  task automatic finish_block();
    int n = 0;
    bus.w_ready = 1'b1;
    while (!(bus.w_valid && bus.w_last) && n < 100) begin tick(); n++; end
    chk("last_timeout", n < 100, 1);
    tick();
    chk("ready_after_last", bus.blk_ready, 1);
    chk("valid_after_last", bus.w_valid, 0);
  endtask

  task automatic run_block(input logic [511:0] b);
    nf = 0;
    bus.w_ready = 1'b1;
    start_block(b);
    finish_block();
    chk("fire_count", nf, 64);
  endtask

  initial begin
    fork monitor(); join_none
    n_chk = 0; n_pass = 0; nf = 0; cyc = 0;
    abc_blk  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    zero_blk = '0;
    ff_blk   = {16{32'hFFFFFFFF}};
    tbl[0]  = '{abc_blk,  0,  32'h61626380};
    tbl[1]  = '{abc_blk,  1,  32'h00000000};
    tbl[2]  = '{abc_blk,  15, 32'h00000018};
    tbl[3]  = '{abc_blk,  16, 32'h61626380};
    tbl[4]  = '{abc_blk,  17, 32'h000F0000};
    tbl[5]  = '{abc_blk,  18, 32'h7DA86405};
    tbl[6]  = '{abc_blk,  63, 32'h12B1EDEB};
    tbl[7]  = '{zero_blk, 0,  32'h00000000};
    tbl[8]  = '{zero_blk, 31, 32'h00000000};
    tbl[9]  = '{zero_blk, 63, 32'h00000000};
    tbl[10] = '{ff_blk,   0,  32'hFFFFFFFF};
    tbl[11] = '{ff_blk,   15, 32'hFFFFFFFF};

    bus.flush = 1'b0; bus.blk = '0; bus.blk_valid = 1'b0; bus.w_ready = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_w_valid",   bus.w_valid,   0);
    chk("rst_w_word",    bus.w_word,    0);
    chk("rst_w_idx",     bus.w_idx,     0);
    chk("rst_w_last",    bus.w_last,    0);
    chk("rst_blk_ready", bus.blk_ready, 1);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i == 0 || tbl[i].blk != tbl[i-1].blk) run_block(tbl[i].blk);
      chk($sformatf("kat_%0d_w%0d", i, tbl[i].idx), cap_w[tbl[i].idx], tbl[i].w);
    end

    // stall three cycles with W[20] on the bus
    nf = 0;
    bus.w_ready = 1'b1;
    start_block(abc_blk);
    wait_idx(20, 100);
    bus.w_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_valid", bus.w_valid, 1);
      chk("stall_idx",   bus.w_idx,   20);
      chk("stall_word",  bus.w_word,  ref_w(abc_blk, 20));
    end
    finish_block();
    chk("stall_fire_count", nf, 64);

    // flush during idx-30 fire while a new block is offered
    bus.w_ready = 1'b1;
    start_block(abc_blk);
    wait_idx(30, 100);
    bus.flush = 1'b1; bus.blk = ff_blk; bus.blk_valid = 1'b1;
    tick();
    chk("flush_valid", bus.w_valid,   0);
    chk("flush_ready", bus.blk_ready, 1);
    chk("flush_idx",   bus.w_idx,     0);
    bus.flush = 1'b0;
    nf = 0;
    tick();
    bus.blk_valid = 1'b0;
    chk("post_flush_valid", bus.w_valid, 1);
    chk("post_flush_idx",   bus.w_idx,   0);
    chk("post_flush_w0",    bus.w_word,  32'hFFFFFFFF);
    finish_block();
    chk("post_flush_fires", nf, 64);

    // asynchronous reset mid-block
    start_block(abc_blk);
    wait_idx(40, 100);
    #2 rst = 1'b1;
    #1;
    chk("arst_w_valid",   bus.w_valid,   0);
    chk("arst_w_word",    bus.w_word,    0);
    chk("arst_w_idx",     bus.w_idx,     0);
    chk("arst_w_last",    bus.w_last,    0);
    chk("arst_blk_ready", bus.blk_ready, 1);
    tick();
    rst = 1'b0;
    run_block(abc_blk);
    chk("arst_w63", cap_w[63], 32'h12B1EDEB);

    // back-to-back blocks with blk_valid held
    acc_q.delete(); last_q.delete();
    begin
      int n = 0;
      bus.w_ready = 1'b1;
      bus.blk = abc_blk; bus.blk_valid = 1'b1;
      tick();
      bus.blk = ff_blk;
      while (acc_q.size() < 2 && n < 200) begin tick(); n++; end
      bus.blk_valid = 1'b0;
      chk("b2b_accept_timeout", n < 200, 1);
      n = 0;
      while (last_q.size() < 2 && n < 200) begin tick(); n++; end
      chk("b2b_last_timeout", n < 200, 1);
      if (acc_q.size() == 2 && last_q.size() == 2) begin
        chk("b2b_accept_after_last", acc_q[1] - last_q[0], 1);
        chk("b2b_total_cycles",      last_q[1] - acc_q[0], 129);
      end
      tick();
      chk("b2b_sb_drained", sb.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Message-schedule expander for the SHA-256 datapath. Accepts one 512-bit padded message block and streams the 64 schedule words W[0..63], one per accepted handshake, to the downstream compression-round core. Uses the σ0/σ1 small-sigma functions (s0s, s1s) for expansion. Holds only a 16-word sliding window, with no 64-word storage.

## Interface
- No parameters. Word width (32), window depth (16) and round count (64) are fixed constants.
- clk  input  1  rising-edge clock, single domain
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort; returns to IDLE and discards the current block
- blk  input  512  padded message block; word 0 = blk[511:480], word 15 = blk[31:0]
- blk_valid  input  1  blk is valid
- blk_ready  output  1  block can be accepted; high only in IDLE
- w_word  output  32  current schedule word W[w_idx]
- w_idx  output  6  index t of w_word, 0..63
- w_last  output  1  high together with w_valid when w_idx == 63
- w_valid  output  1  w_word is valid
- w_ready  input  1  downstream consumes w_word

## Operation
- States: IDLE and RUN.
- In IDLE, blk_ready=1. When blk_valid & blk_ready:
  - load window win[i] = word i of blk, for i = 0..15.
  - set t=0 and go to RUN.
- In RUN: w_valid=1, w_word=win[0], w_idx=t, w_last=(t==63). blk_ready=0.
- Fire = w_valid & w_ready. On fire:
  - win[i] ← win[i+1] for i = 0..14.
  - win[15] ← s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32. Carries out of bit 31 are discarded.
  - t ← t+1.
- This gives W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t]. Words 0..15 come out unmodified.
- Fire at t==63: go to IDLE. The window contents become don't-care. t wraps to 0.
- With no fire in RUN (w_ready=0), w_word, w_idx, w_last and w_valid are held stable. This is the standard valid/ready rule: once asserted, w_valid is never withdrawn before a fire.
- flush=1 in any state:
  - next state IDLE, t=0.
  - flush takes priority over fire and over block acceptance in the same cycle. A block offered in a flush cycle is not accepted.
- blk_valid in RUN is ignored. blk_ready=0, so the block is not lost; the upstream holds it.

## Timing
- Reset values (async assert, apply immediately):
  - state=IDLE, t=0, window=0.
  - w_valid=0, w_word=0, w_idx=0, w_last=0.
  - blk_ready=1.
- Reset mid-RUN aborts the block with no further words. The first clock after deassert can accept a block.
- Latency: a block accepted on edge N gives W[0] valid from edge N onward (w_valid high in cycle N+1).
- Throughput with w_ready held high: 64 words in 64 consecutive cycles. Then 1 IDLE cycle before the next block can be accepted, so one block per 65 cycles.
- blk_ready is decoded from state only, with no combinational path from any input.
- w_* outputs are decoded from registers only.
- Critical path: the 4-input 32-bit add of σ1, W, σ0 and W into win[15]. Implemented as a carry-save pair then one carry-propagate adder.

## Structure
- Shared package sha256_pkg:
  - WORD_W=32, BLK_WORDS=16, ROUNDS=64.
  - state encoding (IDLE, RUN).
  - word typedef.
  - The round-core and padder blocks import the same package.
- Instantiates the existing s0s on win[1] and s1s on win[14]. No new sub-module is needed.
- One file: state register, 6-bit counter, 16×32 window shift register, and the adder.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB. w_last only at idx 63. Exactly 64 fires.
- All-zero block -> 64 words all 0x00000000. blk_ready returns to 1 one cycle after the idx-63 fire.
- "abc" block, w_ready low for 3 cycles at idx 20 -> w_word, w_idx=20 and w_valid held stable. The remaining sequence matches the no-stall run.
- Flush asserted during the idx-30 fire with blk_valid=1 -> next cycle w_valid=0 and blk_ready=1, and the offered block is not accepted. A new all-0xFFFFFFFF block then starts at idx 0 with W0=0xFFFFFFFF.
- rst pulsed asynchronously mid-RUN at idx 40 -> all outputs at their reset values before the next edge. After release, the "abc" block reproduces the reference sequence.
- Back-to-back: blk_valid held high with two different blocks and w_ready=1 -> second block accepted in the cycle after the first w_last. Total 129 cycles from the first accept to the second w_last.
